// File: rtl/prime_sieve_pkg.sv
// Shared types and sizing helpers for the prime sieve engine.
package prime_sieve_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StOuter,
    StOchk,
    StCross,
    StTally,
    StDone
  } sieve_state_e;

  // Headroom over 2*ADDR_W so that i*i and j+i can never wrap.
  localparam int unsigned ProdGuardBits = 2;

  function automatic int unsigned prod_width(input int unsigned addr_w);
    return 2 * addr_w + ProdGuardBits;
  endfunction

endpackage

// File: rtl/sieve_bitmap_ram.sv
// One-bit-wide simple dual-port bitmap: synchronous write, registered read, no reset.
module sieve_bitmap_ram #(
  parameter int unsigned Depth = 1024,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic             wdata_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic             rdata_o
);

  logic mem_q [Depth];
  logic rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/prime_sieve_engine.sv
// Sieve of Eratosthenes over a runtime limit; counts primes below N and streams them
// in ascending order over a valid/ready port.
module prime_sieve_engine
  import prime_sieve_pkg::*;
#(
  parameter int unsigned MAX_N  = 1024,
  parameter int unsigned ADDR_W = $clog2(MAX_N),
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      volume,
  input  logic             start,
  output logic             busy,
  output logic             finished,
  output logic             range_err,
  output logic [CNT_W-1:0] count,
  output logic             prime_valid,
  input  logic             prime_ready,
  output logic [CNT_W-1:0] prime_data
);

  localparam int unsigned NeffW = ADDR_W + 1;
  localparam int unsigned ProdW = prod_width(ADDR_W);
  localparam logic [NeffW-1:0] MaxN = NeffW'(MAX_N);

  sieve_state_e     state_q, state_d;
  logic [NeffW-1:0] neff_q, neff_d;
  logic             range_err_q, range_err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pv_q, pv_d;
  logic [CNT_W-1:0] pdata_q, pdata_d;
  logic [NeffW-1:0] i_q, i_d;
  logic [ProdW-1:0] j_q, j_d;
  logic [NeffW-1:0] k_q, k_d;
  logic             rd_pend_q, rd_pend_d;
  logic [NeffW-1:0] rd_k_q, rd_k_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic              ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic              ram_rdata;

  logic [ProdW-1:0] i_wide, i_sq, j_next, neff_wide;
  logic             out_free, consume;

  assign i_wide    = ProdW'(i_q);
  assign i_sq      = i_wide * i_wide;
  assign j_next    = j_q + i_wide;
  assign neff_wide = ProdW'(neff_q);

  sieve_bitmap_ram #(
    .Depth(MAX_N),
    .AddrW(ADDR_W)
  ) u_bitmap (
    .clk_i  (clk),
    .we_i   (ram_we),
    .waddr_i(ram_waddr),
    .wdata_i(ram_wdata),
    .raddr_i(ram_raddr),
    .rdata_o(ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    neff_d      = neff_q;
    range_err_d = range_err_q;
    count_d     = count_q;
    pv_d        = pv_q;
    pdata_d     = pdata_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    rd_pend_d   = rd_pend_q;
    rd_k_d      = rd_k_q;
    ram_we      = 1'b0;
    ram_waddr   = k_q[ADDR_W-1:0];
    ram_wdata   = 1'b0;
    ram_raddr   = i_q[ADDR_W-1:0];
    out_free    = 1'b0;
    consume     = 1'b0;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          range_err_d = (volume > 32'(MAX_N));
          neff_d      = range_err_d ? MaxN : volume[NeffW-1:0];
          count_d     = '0;
          k_d         = '0;
          state_d     = StInit;
        end
      end
      StInit: begin
        ram_we    = (k_q < neff_q);
        ram_wdata = (k_q >= NeffW'(2));
        k_d       = k_q + NeffW'(1);
        if (k_q + NeffW'(1) >= neff_q) begin
          if (neff_q <= NeffW'(2)) begin
            k_d     = '0;
            state_d = StTally;
          end else begin
            i_d     = NeffW'(2);
            state_d = StOuter;
          end
        end
      end
      StOuter: begin
        if (i_sq >= neff_wide) begin
          k_d     = '0;
          state_d = StTally;
        end else begin
          state_d = StOchk;
        end
      end
      StOchk: begin
        if (ram_rdata) begin
          j_d     = i_sq;
          state_d = StCross;
        end else begin
          i_d     = i_q + NeffW'(1);
          state_d = StOuter;
        end
      end
      StCross: begin
        ram_we    = 1'b1;
        ram_waddr = j_q[ADDR_W-1:0];
        j_d       = j_next;
        if (j_next >= neff_wide) begin
          i_d     = i_q + NeffW'(1);
          state_d = StOuter;
        end
      end
      StTally: begin
        out_free = !pv_q || prime_ready;
        if (pv_q && prime_ready) begin
          pv_d = 1'b0;
        end
        // A pending zero flag never needs the output register; a pending prime waits for it.
        consume = rd_pend_q && (!ram_rdata || out_free);
        if (consume && ram_rdata) begin
          pv_d    = 1'b1;
          pdata_d = CNT_W'(rd_k_q);
          if (count_q != '1) begin
            count_d = count_q + 1'b1;
          end
        end
        if (k_q < neff_q && (!rd_pend_q || consume)) begin
          ram_raddr = k_q[ADDR_W-1:0];
          rd_k_d    = k_q;
          rd_pend_d = 1'b1;
          k_d       = k_q + NeffW'(1);
        end else if (rd_pend_q && !consume) begin
          // Stalled: re-read the same address so the RAM output holds its value.
          ram_raddr = rd_k_q[ADDR_W-1:0];
        end else begin
          rd_pend_d = 1'b0;
        end
        if (k_q >= neff_q && (!rd_pend_q || !ram_rdata) && out_free) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      neff_q      <= '0;
      range_err_q <= 1'b0;
      count_q     <= '0;
      pv_q        <= 1'b0;
      pdata_q     <= '0;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      rd_pend_q   <= 1'b0;
      rd_k_q      <= '0;
    end else begin
      state_q     <= state_d;
      neff_q      <= neff_d;
      range_err_q <= range_err_d;
      count_q     <= count_d;
      pv_q        <= pv_d;
      pdata_q     <= pdata_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      rd_pend_q   <= rd_pend_d;
      rd_k_q      <= rd_k_d;
    end
  end

  assign busy        = (state_q != StIdle) && (state_q != StDone);
  assign finished    = (state_q == StDone);
  assign range_err   = range_err_q;
  assign count       = count_q;
  assign prime_valid = pv_q;
  assign prime_data  = pdata_q;

endmodule
